// File: rtl/instruction_encoder_pkg.sv
// Shared types and constants for the streaming MIPS instruction encoder.
package encoder_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned MEM_DEPTH = 32;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned WORD_W    = 32;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_ADDI = 3'd1,
        KIND_LW   = 3'd2,
        KIND_SW   = 3'd3,
        KIND_BEQ  = 3'd4,
        KIND_J    = 3'd5,
        KIND_ILL6 = 3'd6,
        KIND_ILL7 = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [25:0] target;
    } fields_t;

    // R-type function codes the CPU actually implements.
    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-set handshake and instruction-memory write bus of the encoder.
interface instruction_encoder_if;
    import encoder_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    fields_t              fields;
    logic                 im_we;
    logic [ADDR_W-1:0]    im_addr;
    logic [WORD_W-1:0]    im_wdata;

    modport enc (
        input  in_valid,
        input  fields,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport src (
        output in_valid,
        output fields,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

endinterface

// File: rtl/instruction_encoder_pack.sv
// Combinational field-set to 32-bit MIPS word packer with a legality flag.
module instr_pack
    import encoder_pkg::*;
(
    input  fields_t             fields_i,
    output logic [WORD_W-1:0]   word_c_o,
    output logic                legal_c_o
);

    always_comb begin
        word_c_o  = '0;
        legal_c_o = 1'b1;
        case (fields_i.kind)
            KIND_R: begin
                word_c_o  = {OP_R, fields_i.rs, fields_i.rt, fields_i.rd,
                             fields_i.shamt, fields_i.funct};
                legal_c_o = funct_legal(fields_i.funct) && (fields_i.shamt == 5'd0);
            end
            KIND_ADDI: word_c_o = {OP_ADDI, fields_i.rs, fields_i.rt, fields_i.imm16};
            KIND_LW:   word_c_o = {OP_LW,   fields_i.rs, fields_i.rt, fields_i.imm16};
            KIND_SW:   word_c_o = {OP_SW,   fields_i.rs, fields_i.rt, fields_i.imm16};
            KIND_BEQ:  word_c_o = {OP_BEQ,  fields_i.rs, fields_i.rt, fields_i.imm16};
            KIND_J:    word_c_o = {OP_J,    fields_i.target};
            // Undefined kinds pack to a nop word.
            default:   legal_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming MIPS instruction assembler writing packed words to consecutive addresses.
// Optional field checking is enabled by defining ENCODER_CHECK_EN.
module instruction_encoder
    import encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic                 finish_i,
    instruction_encoder_if.enc   bus,
    output logic [CNT_W-1:0]     count_o,
    output logic                 done_o,
    output logic                 err_o
);

`ifdef ENCODER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [WORD_W-1:0]   im_wdata_q, im_wdata_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [WORD_W-1:0]   word_c;
    logic                legal_c;
    logic                ready_c;
    logic                xfer_c;
    logic                write_ok_c;

    instr_pack u_pack (
        .fields_i  (bus.fields),
        .word_c_o  (word_c),
        .legal_c_o (legal_c)
    );

    // Ready is gated by finish so a transfer and finish never share a cycle.
    assign ready_c    = (state_q == ST_RUN) && !finish_i;
    assign xfer_c     = bus.in_valid && ready_c;
    assign write_ok_c = !CHECK_EN || legal_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            count_q    <= count_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        count_d    = count_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    addr_d  = base_addr_i;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN, ST_FULL: begin
                if (finish_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Writing the last address closes the program to further transfers; no wrap.
        if (xfer_c && write_ok_c) begin
            im_we_d    = 1'b1;
            im_addr_d  = addr_q;
            im_wdata_d = word_c;
            addr_d     = addr_q + ADDR_W'(1);
            count_d    = count_q + CNT_W'(1);
            if (addr_q == LAST_ADDR) begin
                state_d = ST_FULL;
            end
        end

        if (xfer_c && !write_ok_c) begin
            err_d = 1'b1;
        end
    end

    assign bus.in_ready = ready_c;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign count_o      = count_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
